// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (state encoding, defaults, data-bit clamp limits).
package uart_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DIV_W  = 16;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP1  = 3'd4;
    localparam logic [2:0] STOP2  = 3'd5;
    localparam logic [4:0] N_MIN  = 5'd1;
    localparam logic [4:0] N_MAX  = 5'd16;
    function automatic logic [4:0] clamp_bits(input logic [4:0] n);
        return n < N_MIN ? N_MIN : (n > N_MAX ? N_MAX : n);
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter running 1..D with a one-cycle tick at D; D=0 acts as 1.
module uart_baud_gen import uart_pkg::*; #(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] d_eff;
    assign d_eff = div == '0 ? DIV_W'(1) : div;
    assign tick  = en && cnt == d_eff;
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clear || tick)
            cnt <= DIV_W'(1);
        else if (en)
            cnt <= cnt + DIV_W'(1);
        else
            cnt <= '0;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter; start bit, 1..16 data bits LSB-first, optional parity, 1 or 2 stop bits.
module uart_tx import uart_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    input  logic [4:0]        bits_per_word,
    input  logic              parity_en,
    input  logic              parity_even_odd,
    input  logic              two_stop_bit,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    logic [2:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [4:0]        n_q, bit_cnt, n_in;
    logic              par_en_q, par_q, two_q, par_calc, tick, accept;
    logic [DIV_W-1:0]  div_q;
    assign n_in   = clamp_bits(bits_per_word);
    assign busy   = state != IDLE;
    assign accept = start && !busy;
    // parity is resolved at accept time over only the N bits that will be sent
    always_comb begin
        par_calc = parity_even_odd;
        for (int i = 0; i < DATA_W; i++)
            par_calc = par_calc ^ (data_in[i] & (5'(i) < n_in));
    end
    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (busy),
        .div   (div_q),
        .tick  (tick)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            done     <= 1'b0;
            bit_cnt  <= '0;
            shreg    <= '0;
            n_q      <= N_MIN;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            two_q    <= 1'b0;
            div_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= START;
                    tx       <= 1'b0;
                    shreg    <= data_in;
                    n_q      <= n_in;
                    par_en_q <= parity_en;
                    par_q    <= par_calc;
                    two_q    <= two_stop_bit;
                    div_q    <= clk_div;
                end
                START: if (tick) begin
                    state   <= DATA;
                    tx      <= shreg[0];
                    bit_cnt <= '0;
                end
                DATA: if (tick) begin
                    if (bit_cnt == n_q - 5'd1) begin
                        state <= par_en_q ? PARITY : STOP1;
                        tx    <= par_en_q ? par_q : 1'b1;
                    end else begin
                        shreg   <= shreg >> 1;
                        tx      <= shreg[1];
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                PARITY: if (tick) begin
                    state <= STOP1;
                    tx    <= 1'b1;
                end
                STOP1: if (tick) begin
                    state <= two_q ? STOP2 : IDLE;
                    done  <= !two_q;
                end
                STOP2: if (tick) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random frames checked against a bit-list model of the UART frame.
module tb_uart_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] clk_div = '0;
    logic [15:0] data_in = '0;
    logic        start = 1'b0;
    logic [4:0]  bits_per_word = '0;
    logic        parity_en = 1'b0;
    logic        parity_even_odd = 1'b0;
    logic        two_stop_bit = 1'b0;
    logic        tx, busy, done;
    int          vectors = 0;
    int          miscompares = 0;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  n;
        logic        pe;
        logic        odd;
        logic        two;
        logic [15:0] div;
    } cfg_t;

    always #5 clk = ~clk;

    uart_tx dut (
        .clk             (clk),
        .rst             (rst),
        .clk_div         (clk_div),
        .data_in         (data_in),
        .start           (start),
        .bits_per_word   (bits_per_word),
        .parity_en       (parity_en),
        .parity_even_odd (parity_even_odd),
        .two_stop_bit    (two_stop_bit),
        .tx              (tx),
        .busy            (busy),
        .done            (done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic begin_frame(input cfg_t c);
        data_in         = c.data;
        bits_per_word   = c.n;
        parity_en       = c.pe;
        parity_even_odd = c.odd;
        two_stop_bit    = c.two;
        clk_div         = c.div;
        start           = 1'b1;
    endtask

    // Checks a whole frame cycle by cycle and ends at the negedge of the done cycle.
    task automatic check_frame(input cfg_t c, input logic hold);
        logic bits[$];
        int   d, n;
        logic p;
        n = c.n == 0 ? 1 : (c.n > 16 ? 16 : int'(c.n));
        d = c.div == 0 ? 1 : int'(c.div);
        p = c.odd;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(c.data[i]);
            p = p ^ c.data[i];
        end
        if (c.pe) bits.push_back(p);
        bits.push_back(1'b1);
        if (c.two) bits.push_back(1'b1);
        @(negedge clk);
        start = hold;
        foreach (bits[i]) begin
            for (int k = 0; k < d; k++) begin
                chk("tx_bit", tx, bits[i]);
                chk("busy_high", busy, 1'b1);
                chk("done_low", done, 1'b0);
                if (hold) begin
                    data_in         = 16'($urandom);
                    bits_per_word   = 5'($urandom);
                    parity_en       = 1'($urandom);
                    parity_even_odd = 1'($urandom);
                    two_stop_bit    = 1'($urandom);
                    clk_div         = 16'($urandom_range(0, 9));
                end
                @(negedge clk);
            end
        end
        chk("done_pulse", done, 1'b1);
        chk("busy_fall", busy, 1'b0);
        chk("tx_after", tx, 1'b1);
    endtask

    task automatic idle(input int cycles);
        start = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk("idle_tx", tx, 1'b1);
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
        end
    endtask

    task automatic frame(input cfg_t c);
        begin_frame(c);
        check_frame(c, 1'b0);
        idle(2);
    endtask

    initial begin
        cfg_t c, c2;
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        idle(2);
        c = '{16'h0055, 5'd8, 1'b0, 1'b0, 1'b0, 16'd4};
        frame(c);
        c = '{16'h0007, 5'd8, 1'b1, 1'b0, 1'b0, 16'd2};
        frame(c);
        c = '{16'h0007, 5'd8, 1'b1, 1'b1, 1'b0, 16'd2};
        frame(c);
        c = '{16'hA5C3, 5'd16, 1'b0, 1'b0, 1'b1, 16'd3};
        frame(c);
        c  = '{16'h3C96, 5'd12, 1'b1, 1'b1, 1'b0, 16'd3};
        c2 = '{16'h00E1, 5'd8, 1'b1, 1'b0, 1'b1, 16'd2};
        begin_frame(c);
        check_frame(c, 1'b1);
        begin_frame(c2);
        check_frame(c2, 1'b0);
        idle(5);
        c = '{16'h00FF, 5'd8, 1'b0, 1'b0, 1'b0, 16'd4};
        begin_frame(c);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        rst = 1'b0;
        idle(3);
        c = '{16'h00B4, 5'd8, 1'b1, 1'b0, 1'b0, 16'd4};
        frame(c);
        c = '{16'h0002, 5'd5, 1'b1, 1'b0, 1'b1, 16'd0};
        frame(c);
        c = '{16'hFFFF, 5'd0, 1'b1, 1'b0, 1'b0, 16'd1};
        frame(c);
        c = '{16'h0000, 5'd0, 1'b1, 1'b1, 1'b0, 16'd2};
        frame(c);
        c = '{16'h8001, 5'd31, 1'b1, 1'b0, 1'b0, 16'd1};
        frame(c);
        for (int r = 0; r < 25; r++) begin
            c.data = 16'($urandom);
            c.n    = 5'($urandom_range(0, 31));
            c.pe   = 1'($urandom);
            c.odd  = 1'($urandom);
            c.two  = 1'($urandom);
            c.div  = 16'($urandom_range(0, 5));
            frame(c);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter; the transmit counterpart to the team's uart_rx.
- Serialises one frame per accepted request: start bit, 1..16 data bits LSB-first, optional parity bit, 1 or 2 stop bits.
- Line rate is set by a runtime clock divider.
- Sits between the register/bus interface (data + start strobe) and the tx pin.

Parameters:
- DATA_W, 16, width of data_in and maximum data bits per frame.
- DIV_W, 16, width of clk_div and of the internal baud counter.

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  reset; synchronous, active-high.
- clk_div  input  DIV_W  clock cycles per bit period D; value 0 is treated as 1.
- data_in  input  DATA_W  word to send; bit 0 is transmitted first.
- start  input  1  request strobe; accepted only when busy=0.
- bits_per_word  input  5  data bits N; 0 treated as 1, values >16 treated as 16.
- parity_en  input  1  1 = append parity bit.
- parity_even_odd  input  1  0 = even parity, 1 = odd parity.
- two_stop_bit  input  1  1 = two stop bits, 0 = one.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (any cycle, including mid-frame): on the next edge tx=1, busy=0, done=0, state=IDLE, baud counter=0. A partial frame is abandoned with no completion pulse.
- Accept: start=1 while busy=0 latches data_in, N, parity_en, parity_even_odd, two_stop_bit and clk_div.
  - Later input changes do not affect the frame in flight.
  - start while busy=1 is ignored; it is not queued.
- Latency: the edge after accept sets busy=1 and tx=0 (start bit), and restarts the baud counter at 1.
- Bit timing: each bit holds tx for exactly D cycles. The baud counter wraps at D and produces a 1-cycle bit tick that advances the FSM.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE -> START on accept.
  - START -> DATA on tick.
  - DATA sends latched bit[bit_pos], bit_pos 0..N-1. On tick at bit_pos=N-1, go to PARITY if parity_en, else STOP1.
  - PARITY -> STOP1 on tick.
  - STOP1 -> STOP2 on tick if two_stop_bit, else -> IDLE.
  - STOP2 -> IDLE on tick.
- Parity: XOR of the N transmitted data bits only (bits above N-1 are excluded), inverted when parity_even_odd=1.
- Stop bits: tx=1.
- Completion: the edge ending the last stop bit sets state=IDLE, busy=0, done=1 for exactly one cycle; tx stays 1.
  - Total busy duration = (1+N+P+S)*D cycles, where P is 0/1 and S is 1/2.
- Back-to-back: a start in the done cycle is accepted, so the next start bit begins on the following edge. The minimum inter-frame idle is 1 cycle.
- Unused states: any illegal encoding -> IDLE with tx=1.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams (IDLE..STOP2, 3 bits), shared with uart_rx;
  - DATA_W, DIV_W defaults;
  - the N clamp limits.
- One sub-module, uart_baud_gen: counter with clear input, D=0 -> 1 handling, tick output. It is reusable by uart_rx.

Test Plan:
- D=4, N=8, no parity, 1 stop, data 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; busy high 40 cycles; done pulses once as busy falls.
- D=2, N=8, parity_en=1: data 0x07 with even parity -> parity bit 1; data 0x07 with odd parity -> parity bit 0; frame = 11 bits = 22 cycles.
- D=3, N=16, two_stop_bit=1, data 0xA5C3 -> LSB-first bits of 0xA5C3 after the start bit, then tx=1 for 6 cycles; busy 57 cycles.
- Start asserted on every cycle of a frame plus during the done cycle -> exactly two frames; the second start bit begins 1 cycle after done; mid-frame data_in changes are not transmitted.
- rst asserted mid-DATA (D=4, N=8) -> next edge tx=1, busy=0, done=0; a new start after reset produces a full correct frame.
- Boundaries: clk_div=0 behaves as D=1 (one-cycle bits); bits_per_word=0 sends 1 data bit; bits_per_word=31 sends 16 data bits.
